// File: rtl/dual_helix_pkg.sv
// rtl/dual_helix_pkg.sv - AXI4-Lite request/response structs shared across the dual-helix SoC
package dual_helix_pkg;

    typedef struct packed {
        logic [31:0] addr;
    } dhs_axil_ax_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
    } dhs_axil_w_t;

    typedef struct packed {
        logic [1:0] resp;
    } dhs_axil_b_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dhs_axil_r_t;

    typedef struct packed {
        dhs_axil_ax_t aw;
        logic         aw_valid;
        dhs_axil_w_t  w;
        logic         w_valid;
        logic         b_ready;
        dhs_axil_ax_t ar;
        logic         ar_valid;
        logic         r_ready;
    } dhs_axil_req_t;

    typedef struct packed {
        logic         aw_ready;
        logic         w_ready;
        dhs_axil_b_t  b;
        logic         b_valid;
        logic         ar_ready;
        dhs_axil_r_t  r;
        logic         r_valid;
    } dhs_axil_resp_t;

endpackage

// File: rtl/soc_ctrl_pkg.sv
// rtl/soc_ctrl_pkg.sv - register map, field positions and reset values of the SoC control block
package soc_ctrl_pkg;

    localparam int SC_NUM_REGS = 16;

    localparam logic [31:0] SC_BOOT_ADDR_CORE_0_ADDR    = 32'h00;
    localparam logic [31:0] SC_BOOT_ADDR_CORE_1_ADDR    = 32'h04;
    localparam logic [31:0] SC_HART_ID_CORE_0_ADDR      = 32'h08;
    localparam logic [31:0] SC_HART_ID_CORE_1_ADDR      = 32'h0C;
    localparam logic [31:0] SC_MTVEC_CORE_0_ADDR        = 32'h10;
    localparam logic [31:0] SC_MTVEC_CORE_1_ADDR        = 32'h14;
    localparam logic [31:0] SC_CLK_RST_CORE_0_ADDR      = 32'h18;
    localparam logic [31:0] SC_CLK_RST_CORE_1_ADDR      = 32'h1C;
    localparam logic [31:0] SC_CLK_RST_CORE_LINK_ADDR   = 32'h20;
    localparam logic [31:0] SC_CLK_RST_SYS_LINK_ADDR    = 32'h24;
    localparam logic [31:0] SC_CLK_RST_PERIPH_LINK_ADDR = 32'h28;
    localparam logic [31:0] SC_PLL_CONFIG_CORE_0_ADDR   = 32'h2C;
    localparam logic [31:0] SC_PLL_CONFIG_CORE_1_ADDR   = 32'h30;
    localparam logic [31:0] SC_PLL_CONFIG_SYS_LINK_ADDR = 32'h34;
    localparam logic [31:0] SC_GPR_0_ADDR               = 32'h38;
    localparam logic [31:0] SC_GPR_1_ADDR               = 32'h3C;
    localparam logic [31:0] SC_BOOT_MODE_ADDR           = 32'h40;

    // Word indices into the writable register array (everything below BOOT_MODE)
    localparam int SC_BOOT_ADDR_CORE_0_IDX    = int'(SC_BOOT_ADDR_CORE_0_ADDR >> 2);
    localparam int SC_BOOT_ADDR_CORE_1_IDX    = int'(SC_BOOT_ADDR_CORE_1_ADDR >> 2);
    localparam int SC_HART_ID_CORE_0_IDX      = int'(SC_HART_ID_CORE_0_ADDR >> 2);
    localparam int SC_HART_ID_CORE_1_IDX      = int'(SC_HART_ID_CORE_1_ADDR >> 2);
    localparam int SC_MTVEC_CORE_0_IDX        = int'(SC_MTVEC_CORE_0_ADDR >> 2);
    localparam int SC_MTVEC_CORE_1_IDX        = int'(SC_MTVEC_CORE_1_ADDR >> 2);
    localparam int SC_CLK_RST_CORE_0_IDX      = int'(SC_CLK_RST_CORE_0_ADDR >> 2);
    localparam int SC_CLK_RST_CORE_1_IDX      = int'(SC_CLK_RST_CORE_1_ADDR >> 2);
    localparam int SC_CLK_RST_CORE_LINK_IDX   = int'(SC_CLK_RST_CORE_LINK_ADDR >> 2);
    localparam int SC_CLK_RST_SYS_LINK_IDX    = int'(SC_CLK_RST_SYS_LINK_ADDR >> 2);
    localparam int SC_CLK_RST_PERIPH_LINK_IDX = int'(SC_CLK_RST_PERIPH_LINK_ADDR >> 2);
    localparam int SC_PLL_CONFIG_CORE_0_IDX   = int'(SC_PLL_CONFIG_CORE_0_ADDR >> 2);
    localparam int SC_PLL_CONFIG_CORE_1_IDX   = int'(SC_PLL_CONFIG_CORE_1_ADDR >> 2);
    localparam int SC_PLL_CONFIG_SYS_LINK_IDX = int'(SC_PLL_CONFIG_SYS_LINK_ADDR >> 2);
    localparam int SC_GPR_0_IDX               = int'(SC_GPR_0_ADDR >> 2);
    localparam int SC_GPR_1_IDX               = int'(SC_GPR_1_ADDR >> 2);

    localparam int SC_CLK_EN_BIT  = 0;
    localparam int SC_RST_REL_BIT = 1;
    localparam int SC_CLK_SEL_BIT = 2;

    localparam int SC_REF_DIV_BW = 4;
    localparam int SC_FB_DIV_BW  = 12;

    localparam logic [31:0] SC_HART_ID_CORE_1_RST      = 32'h1;
    localparam logic [31:0] SC_CLK_RST_PERIPH_LINK_RST = 32'h3;

    localparam logic [1:0] SC_RESP_OKAY   = 2'b00;
    localparam logic [1:0] SC_RESP_SLVERR = 2'b10;

    function automatic logic [31:0] sc_reg_reset(input int idx);
        case (idx)
            SC_HART_ID_CORE_1_IDX:      return SC_HART_ID_CORE_1_RST;
            SC_CLK_RST_PERIPH_LINK_IDX: return SC_CLK_RST_PERIPH_LINK_RST;
            default:                    return 32'h0;
        endcase
    endfunction

    // Bits that actually exist in each register; the rest are stored as 0 and read back 0
    function automatic logic [31:0] sc_reg_wmask(input int idx);
        case (idx)
            SC_CLK_RST_CORE_0_IDX,
            SC_CLK_RST_CORE_1_IDX,
            SC_CLK_RST_SYS_LINK_IDX,
            SC_CLK_RST_PERIPH_LINK_IDX: return 32'h3;
            SC_CLK_RST_CORE_LINK_IDX:   return 32'h7;
            SC_PLL_CONFIG_CORE_0_IDX,
            SC_PLL_CONFIG_CORE_1_IDX,
            SC_PLL_CONFIG_SYS_LINK_IDX: return (32'h1 << (SC_REF_DIV_BW + SC_FB_DIV_BW)) - 32'h1;
            default:                    return 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/soc_ctrl_clk_gate.sv
// rtl/soc_ctrl_clk_gate.sv - latch-based integrated clock gate for one clock domain
// Ports: clk_i source clock, rst_i async active-high reset (forces gate closed),
//        en_i enable from register file, clk_o gated clock.
module soc_ctrl_clk_gate (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic clk_o
);

    logic en_latched;

    // Transparent only while clk_i is low, so the enable cannot change during a high phase
    always_latch begin
        if (rst_i) begin
            en_latched <= 1'b0;
        end else if (!clk_i) begin
            en_latched <= en_i;
        end
    end

    assign clk_o = clk_i & en_latched;

endmodule

// File: rtl/soc_ctrl_top.sv
// rtl/soc_ctrl_top.sv - AXI4-Lite register file driving core boot config, domain clocks/resets and PLL config
// Ports: ref_clk_i sole clock; glb_arst_i async active-high reset; axil_req_i/axil_resp_o AXI-Lite slave;
//        core_x_boot_addr_o/hart_id_o/mtvec_o boot config; boot_mode_i async strap; gpr0_o/gpr1_o;
//        <domain>_clk_o/arst_n_o/clk_en_o per domain; pll_<domain>_cfg_o {fb_div, ref_div}.
module soc_ctrl_top
    import soc_ctrl_pkg::*;
#(
    parameter type         req_t      = dual_helix_pkg::dhs_axil_req_t,
    parameter type         resp_t     = dual_helix_pkg::dhs_axil_resp_t,
    parameter logic [31:0] MEM_BASE   = 32'h0,
    parameter logic [31:0] MEM_SIZE   = 32'h1000,
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter int          REF_DIV_BW = 4,
    parameter int          FB_DIV_BW  = 12
) (
    input  logic                              ref_clk_i,
    input  logic                              glb_arst_i,
    input  req_t                              axil_req_i,
    output resp_t                             axil_resp_o,
    output logic [DATA_WIDTH-1:0]             core_0_boot_addr_o,
    output logic [DATA_WIDTH-1:0]             core_1_boot_addr_o,
    output logic [DATA_WIDTH-1:0]             core_0_hart_id_o,
    output logic [DATA_WIDTH-1:0]             core_1_hart_id_o,
    output logic [DATA_WIDTH-1:0]             core_0_mtvec_o,
    output logic [DATA_WIDTH-1:0]             core_1_mtvec_o,
    input  logic                              boot_mode_i,
    output logic [DATA_WIDTH-1:0]             gpr0_o,
    output logic [DATA_WIDTH-1:0]             gpr1_o,
    output logic                              core_0_clk_o,
    output logic                              core_0_arst_n_o,
    output logic                              core_0_clk_en_o,
    output logic                              core_1_clk_o,
    output logic                              core_1_arst_n_o,
    output logic                              core_1_clk_en_o,
    output logic                              core_link_clk_o,
    output logic                              core_link_arst_n_o,
    output logic                              core_link_clk_en_o,
    output logic                              sys_link_clk_o,
    output logic                              sys_link_arst_n_o,
    output logic                              sys_link_clk_en_o,
    output logic                              periph_link_arst_n_o,
    output logic                              periph_link_clk_en_o,
    output logic [REF_DIV_BW+FB_DIV_BW-1:0]   pll_core_0_cfg_o,
    output logic [REF_DIV_BW+FB_DIV_BW-1:0]   pll_core_1_cfg_o,
    output logic [REF_DIV_BW+FB_DIV_BW-1:0]   pll_sys_link_cfg_o
);

    localparam int CFG_W = REF_DIV_BW + FB_DIV_BW;

    logic [DATA_WIDTH-1:0] regs [SC_NUM_REGS];
    logic [1:0]            boot_sync;

    logic [ADDR_WIDTH-1:0] wr_off;
    logic [ADDR_WIDTH-1:0] rd_off;
    logic [3:0]            wr_idx;
    logic [3:0]            rd_idx;
    logic                  wr_fire;
    logic                  wr_ok;
    logic                  rd_fire;
    logic [DATA_WIDTH-1:0] wr_merged;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [1:0]            rd_resp;
    logic                  unused_bits;

    logic                  b_valid;
    logic [1:0]            b_resp;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic [1:0]            r_resp;

    // ---------------- decode ----------------
    // Subtracting the base lets an address below MEM_BASE wrap to a huge offset, which fails the window test
    assign wr_off  = axil_req_i.aw.addr - MEM_BASE;
    assign rd_off  = axil_req_i.ar.addr - MEM_BASE;
    assign wr_idx  = wr_off[5:2];
    assign rd_idx  = rd_off[5:2];
    assign wr_ok   = (wr_off < MEM_SIZE) && (wr_off < SC_BOOT_MODE_ADDR);
    assign unused_bits = ^{wr_off[1:0], rd_off[1:0]};

    // Address and data are only taken as a pair, and never while a B is still outstanding
    assign wr_fire = axil_req_i.aw_valid & axil_req_i.w_valid & ~b_valid;
    assign rd_fire = axil_req_i.ar_valid & ~r_valid;

    always_comb begin
        wr_merged = regs[wr_idx];
        for (int b = 0; b < DATA_WIDTH / 8; b++) begin
            if (axil_req_i.w.strb[b]) begin
                wr_merged[8*b +: 8] = axil_req_i.w.data[8*b +: 8];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_resp = SC_RESP_SLVERR;
        if ((rd_off < MEM_SIZE) && (rd_off < SC_BOOT_MODE_ADDR)) begin
            rd_data = regs[rd_idx];
            rd_resp = SC_RESP_OKAY;
        end else if ((rd_off < MEM_SIZE) && ({rd_off[ADDR_WIDTH-1:2], 2'b00} == SC_BOOT_MODE_ADDR)) begin
            rd_data = {{(DATA_WIDTH-1){1'b0}}, boot_sync[1]};
            rd_resp = SC_RESP_OKAY;
        end
    end

    // ---------------- register file + write channel ----------------
    always_ff @(posedge ref_clk_i or posedge glb_arst_i) begin
        if (glb_arst_i) begin
            for (int i = 0; i < SC_NUM_REGS; i++) begin
                regs[i] <= sc_reg_reset(i);
            end
            b_valid <= 1'b0;
            b_resp  <= SC_RESP_OKAY;
        end else begin
            if (wr_fire) begin
                b_valid <= 1'b1;
                b_resp  <= wr_ok ? SC_RESP_OKAY : SC_RESP_SLVERR;
                if (wr_ok) begin
                    regs[wr_idx] <= wr_merged & sc_reg_wmask(int'(wr_idx));
                end
            end else if (b_valid && axil_req_i.b_ready) begin
                b_valid <= 1'b0;
            end
        end
    end

    // ---------------- read channel ----------------
    // Data is captured from the pre-edge register values, so a same-cycle write is not visible
    always_ff @(posedge ref_clk_i or posedge glb_arst_i) begin
        if (glb_arst_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_resp  <= SC_RESP_OKAY;
        end else begin
            if (rd_fire) begin
                r_valid <= 1'b1;
                r_data  <= rd_data;
                r_resp  <= rd_resp;
            end else if (r_valid && axil_req_i.r_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge ref_clk_i or posedge glb_arst_i) begin
        if (glb_arst_i) begin
            boot_sync <= 2'b00;
        end else begin
            boot_sync <= {boot_sync[0], boot_mode_i};
        end
    end

    always_comb begin
        axil_resp_o          = '0;
        axil_resp_o.aw_ready = wr_fire;
        axil_resp_o.w_ready  = wr_fire;
        axil_resp_o.b_valid  = b_valid;
        axil_resp_o.b.resp   = b_resp;
        axil_resp_o.ar_ready = ~r_valid;
        axil_resp_o.r_valid  = r_valid;
        axil_resp_o.r.data   = r_data;
        axil_resp_o.r.resp   = r_resp;
    end

    // ---------------- configuration outputs ----------------
    assign core_0_boot_addr_o = regs[SC_BOOT_ADDR_CORE_0_IDX];
    assign core_1_boot_addr_o = regs[SC_BOOT_ADDR_CORE_1_IDX];
    assign core_0_hart_id_o   = regs[SC_HART_ID_CORE_0_IDX];
    assign core_1_hart_id_o   = regs[SC_HART_ID_CORE_1_IDX];
    assign core_0_mtvec_o     = regs[SC_MTVEC_CORE_0_IDX];
    assign core_1_mtvec_o     = regs[SC_MTVEC_CORE_1_IDX];
    assign gpr0_o             = regs[SC_GPR_0_IDX];
    assign gpr1_o             = regs[SC_GPR_1_IDX];

    assign pll_core_0_cfg_o   = regs[SC_PLL_CONFIG_CORE_0_IDX][CFG_W-1:0];
    assign pll_core_1_cfg_o   = regs[SC_PLL_CONFIG_CORE_1_IDX][CFG_W-1:0];
    assign pll_sys_link_cfg_o = regs[SC_PLL_CONFIG_SYS_LINK_IDX][CFG_W-1:0];

    assign core_0_clk_en_o      = regs[SC_CLK_RST_CORE_0_IDX][SC_CLK_EN_BIT];
    assign core_1_clk_en_o      = regs[SC_CLK_RST_CORE_1_IDX][SC_CLK_EN_BIT];
    assign core_link_clk_en_o   = regs[SC_CLK_RST_CORE_LINK_IDX][SC_CLK_EN_BIT];
    assign sys_link_clk_en_o    = regs[SC_CLK_RST_SYS_LINK_IDX][SC_CLK_EN_BIT];
    assign periph_link_clk_en_o = regs[SC_CLK_RST_PERIPH_LINK_IDX][SC_CLK_EN_BIT];

    // Reset assertion bypasses the clock; release waits for software to set rst_release
    assign core_0_arst_n_o      = regs[SC_CLK_RST_CORE_0_IDX][SC_RST_REL_BIT] & ~glb_arst_i;
    assign core_1_arst_n_o      = regs[SC_CLK_RST_CORE_1_IDX][SC_RST_REL_BIT] & ~glb_arst_i;
    assign core_link_arst_n_o   = regs[SC_CLK_RST_CORE_LINK_IDX][SC_RST_REL_BIT] & ~glb_arst_i;
    assign sys_link_arst_n_o    = regs[SC_CLK_RST_SYS_LINK_IDX][SC_RST_REL_BIT] & ~glb_arst_i;
    assign periph_link_arst_n_o = regs[SC_CLK_RST_PERIPH_LINK_IDX][SC_RST_REL_BIT] & ~glb_arst_i;

    // ---------------- domain clocks ----------------
    soc_ctrl_clk_gate u_gate_core_0 (
        .clk_i (ref_clk_i),
        .rst_i (glb_arst_i),
        .en_i  (core_0_clk_en_o),
        .clk_o (core_0_clk_o)
    );

    soc_ctrl_clk_gate u_gate_core_1 (
        .clk_i (ref_clk_i),
        .rst_i (glb_arst_i),
        .en_i  (core_1_clk_en_o),
        .clk_o (core_1_clk_o)
    );

    soc_ctrl_clk_gate u_gate_sys_link (
        .clk_i (ref_clk_i),
        .rst_i (glb_arst_i),
        .en_i  (sys_link_clk_en_o),
        .clk_o (sys_link_clk_o)
    );

    // Both candidates are gated copies of ref_clk_i in phase, and clk_sel only moves on a rising
    // edge while both are high, so the switch cannot cut a pulse short when both are running.
    assign core_link_clk_o = regs[SC_CLK_RST_CORE_LINK_IDX][SC_CLK_SEL_BIT] ? core_1_clk_o : core_0_clk_o;

endmodule

// File: tb/tb_soc_ctrl_top.sv
// tb/tb_soc_ctrl_top.sv - scoreboard bench for soc_ctrl_top
module tb_soc_ctrl_top;
    import dual_helix_pkg::*;

    logic ref_clk   = 1'b0;
    logic glb_arst  = 1'b1;
    logic boot_mode = 1'b0;
    dhs_axil_req_t  req;
    dhs_axil_resp_t resp;

    logic [31:0] c0_boot, c1_boot, c0_hart, c1_hart, c0_mtvec, c1_mtvec, gpr0, gpr1;
    logic c0_clk, c0_rstn, c0_en, c1_clk, c1_rstn, c1_en;
    logic cl_clk, cl_rstn, cl_en, sl_clk, sl_rstn, sl_en, pl_rstn, pl_en;
    logic [15:0] pll0, pll1, pll_sl;

    soc_ctrl_top dut (
        .ref_clk_i            (ref_clk),
        .glb_arst_i           (glb_arst),
        .axil_req_i           (req),
        .axil_resp_o          (resp),
        .core_0_boot_addr_o   (c0_boot),
        .core_1_boot_addr_o   (c1_boot),
        .core_0_hart_id_o     (c0_hart),
        .core_1_hart_id_o     (c1_hart),
        .core_0_mtvec_o       (c0_mtvec),
        .core_1_mtvec_o       (c1_mtvec),
        .boot_mode_i          (boot_mode),
        .gpr0_o               (gpr0),
        .gpr1_o               (gpr1),
        .core_0_clk_o         (c0_clk),
        .core_0_arst_n_o      (c0_rstn),
        .core_0_clk_en_o      (c0_en),
        .core_1_clk_o         (c1_clk),
        .core_1_arst_n_o      (c1_rstn),
        .core_1_clk_en_o      (c1_en),
        .core_link_clk_o      (cl_clk),
        .core_link_arst_n_o   (cl_rstn),
        .core_link_clk_en_o   (cl_en),
        .sys_link_clk_o       (sl_clk),
        .sys_link_arst_n_o    (sl_rstn),
        .sys_link_clk_en_o    (sl_en),
        .periph_link_arst_n_o (pl_rstn),
        .periph_link_clk_en_o (pl_en),
        .pll_core_0_cfg_o     (pll0),
        .pll_core_1_cfg_o     (pll1),
        .pll_sys_link_cfg_o   (pll_sl)
    );

    always #5 ref_clk = ~ref_clk;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mdl [16];
    logic [1:0]  bq [$];
    logic [33:0] rq [$];

    int  e_c0 = 0, e_c1 = 0, e_cl = 0, e_sl = 0, runts = 0;
    time t_rise = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    always @(posedge c0_clk) e_c0++;
    always @(posedge c1_clk) e_c1++;
    always @(posedge sl_clk) e_sl++;
    always @(posedge cl_clk) begin
        e_cl++;
        t_rise = $time;
    end
    always @(negedge cl_clk) if ($time - t_rise < 5) runts++;

    always @(negedge ref_clk) begin
        if (resp.b_valid && req.b_ready) begin
            if (bq.size() == 0) check("b_unexpected", 32'd1, 32'd0);
            else check("bresp", {30'b0, resp.b.resp}, {30'b0, bq.pop_front()});
        end
        if (resp.r_valid && req.r_ready) begin
            if (rq.size() == 0) check("r_unexpected", 32'd1, 32'd0);
            else begin
                logic [33:0] e;
                e = rq.pop_front();
                check("rresp", {30'b0, resp.r.resp}, {30'b0, e[33:32]});
                check("rdata", resp.r.data, e[31:0]);
            end
        end
    end

    function automatic logic [31:0] wmask(input int idx);
        if (idx == 6 || idx == 7 || idx == 9 || idx == 10) return 32'h3;
        if (idx == 8) return 32'h7;
        if (idx >= 11 && idx <= 13) return 32'hFFFF;
        return 32'hFFFF_FFFF;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
        mdl[3]  = 32'h1;
        mdl[10] = 32'h3;
    endtask

    task automatic xact(input bit do_wr, input logic [31:0] waddr, input logic [31:0] wdata,
                        input logic [3:0] strb, input bit do_rd, input logic [31:0] raddr);
        int t;
        int idx;
        logic [31:0] merged;
        if (do_rd) begin
            if (raddr < 32'h40) rq.push_back({2'b00, mdl[raddr[5:2]]});
            else if (raddr[31:2] == 30'h10) rq.push_back({2'b00, 31'b0, boot_mode});
            else rq.push_back({2'b10, 32'h0});
        end
        if (do_wr) begin
            if (waddr < 32'h40) begin
                idx = int'(waddr[5:2]);
                merged = mdl[idx];
                for (int b = 0; b < 4; b++) if (strb[b]) merged[8*b +: 8] = wdata[8*b +: 8];
                mdl[idx] = merged & wmask(idx);
                bq.push_back(2'b00);
            end else begin
                bq.push_back(2'b10);
            end
        end
        @(negedge ref_clk);
        req.aw.addr  = waddr;
        req.w.data   = wdata;
        req.w.strb   = strb;
        req.aw_valid = do_wr;
        req.w_valid  = do_wr;
        req.ar.addr  = raddr;
        req.ar_valid = do_rd;
        #1;
        t = 0;
        while (!((!do_wr || resp.aw_ready) && (!do_rd || resp.ar_ready)) && t < 20) begin
            @(negedge ref_clk);
            t++;
        end
        if (t >= 20) check("accept_timeout", t, 0);
        @(posedge ref_clk);
        #1;
        req.aw_valid = 1'b0;
        req.w_valid  = 1'b0;
        req.ar_valid = 1'b0;
        t = 0;
        while ((bq.size() != 0 || rq.size() != 0) && t < 20) begin
            @(negedge ref_clk);
            t++;
        end
        if (bq.size() + rq.size() != 0) begin
            check("resp_timeout", bq.size() + rq.size(), 0);
            bq.delete();
            rq.delete();
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        xact(1'b1, a, d, 4'hF, 1'b0, 32'h0);
    endtask

    task automatic rd(input logic [31:0] a);
        xact(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, a);
    endtask

    task automatic read_all();
        for (int i = 0; i < 16; i++) rd(32'(i * 4));
    endtask

    task automatic count_edges(output int c0, output int c1, output int cl, output int sl);
        int s0, s1, sc, ss;
        @(negedge ref_clk);
        s0 = e_c0; s1 = e_c1; sc = e_cl; ss = e_sl;
        repeat (10) @(negedge ref_clk);
        c0 = e_c0 - s0; c1 = e_c1 - s1; cl = e_cl - sc; sl = e_sl - ss;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, cl, sl, r0;
        req = '0;
        req.b_ready = 1'b1;
        req.r_ready = 1'b1;
        model_reset();

        // reset state
        repeat (3) @(negedge ref_clk);
        check("rst_c0_rstn", c0_rstn, 0);
        check("rst_c1_rstn", c1_rstn, 0);
        check("rst_cl_rstn", cl_rstn, 0);
        check("rst_sl_rstn", sl_rstn, 0);
        check("rst_pl_rstn", pl_rstn, 0);
        check("rst_c0_en", c0_en, 0);
        check("rst_pl_en", pl_en, 1);
        check("rst_hart1", c1_hart, 32'h1);
        count_edges(c0, c1, cl, sl);
        check("rst_clk_c0", c0, 0);
        check("rst_clk_c1", c1, 0);
        check("rst_clk_sl", sl, 0);
        @(negedge ref_clk);
        glb_arst = 1'b0;
        @(negedge ref_clk);
        check("post_rst_pl_rstn", pl_rstn, 1);
        check("post_rst_c0_rstn", c0_rstn, 0);
        read_all();
        rd(32'h40);

        // PLL sys link: ref_div=4, fb_div=0x140
        wr(32'h34, 32'h0000_1404);
        rd(32'h34);
        check("pll_sl_cfg", {16'h0, pll_sl}, {16'h0, 12'h140, 4'h4});

        // sys link clock/reset sequence
        wr(32'h24, 32'h1);
        count_edges(c0, c1, cl, sl);
        check("sl_on_edges", sl, 10);
        check("sl_on_rstn", sl_rstn, 0);
        check("sl_on_en", sl_en, 1);
        wr(32'h24, 32'h0);
        count_edges(c0, c1, cl, sl);
        check("sl_off_edges", sl, 0);
        wr(32'h24, 32'h3);
        count_edges(c0, c1, cl, sl);
        check("sl_run_edges", sl, 10);
        check("sl_run_rstn", sl_rstn, 1);

        // cores
        wr(32'h2C, 32'h1F4A);
        wr(32'h30, 32'h190A);
        check("pll0_cfg", {16'h0, pll0}, 32'h1F4A);
        check("pll1_cfg", {16'h0, pll1}, 32'h190A);
        wr(32'h18, 32'h1);
        wr(32'h1C, 32'h1);
        count_edges(c0, c1, cl, sl);
        check("c0_edges", c0, 10);
        check("c1_edges", c1, 10);
        check("c0_rstn_held", c0_rstn, 0);
        check("c1_rstn_held", c1_rstn, 0);
        wr(32'h18, 32'h3);
        wr(32'h1C, 32'h3);
        check("c0_rstn_rel", c0_rstn, 1);
        check("c1_rstn_rel", c1_rstn, 1);

        // core link: follow core_0, then switch to core_1 while both run
        wr(32'h1C, 32'h2);
        wr(32'h20, 32'h3);
        count_edges(c0, c1, cl, sl);
        check("cl_sel0_edges", cl, 10);
        check("cl_sel0_c1_edges", c1, 0);
        check("cl_rstn", cl_rstn, 1);
        check("cl_en", cl_en, 1);
        wr(32'h1C, 32'h3);
        r0 = runts;
        wr(32'h20, 32'h7);
        wr(32'h18, 32'h2);
        count_edges(c0, c1, cl, sl);
        check("cl_sel1_edges", cl, 10);
        check("cl_sel1_c0_edges", c0, 0);
        check("cl_runts", runts - r0, 0);

        // error responses
        wr(32'h40, 32'h1);
        wr(32'h100, 32'hDEAD_BEEF);
        wr(32'h2000, 32'h1234_5678);
        rd(32'h100);
        rd(32'h2000);
        boot_mode = 1'b1;
        repeat (3) @(negedge ref_clk);
        rd(32'h40);
        rd(32'h42);

        // byte strobes
        wr(32'h38, 32'h1122_3344);
        xact(1'b1, 32'h38, 32'hAABB_CCDD, 4'b0010, 1'b0, 32'h0);
        check("gpr0_strb", gpr0, 32'h1122_CC44);
        rd(32'h3B);

        // same-cycle read and write of one register returns the old value
        xact(1'b1, 32'h3C, 32'hCAFE_F00D, 4'hF, 1'b1, 32'h3C);
        rd(32'h3C);
        check("gpr1_out", gpr1, 32'hCAFE_F00D);
        read_all();

        // asynchronous reset mid-run
        @(negedge ref_clk);
        glb_arst = 1'b1;
        #1;
        check("arst_c0_rstn", c0_rstn, 0);
        check("arst_gpr0", gpr0, 32'h0);
        model_reset();
        repeat (3) @(negedge ref_clk);
        glb_arst = 1'b0;
        read_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
